// File: rtl/ex_hazard_controller_pkg.sv
// ex_hazard_controller_pkg: shared types, FSM encodings and hazard helper for the EX hazard controller.
package ex_hazard_controller_pkg;

    typedef logic [4:0] reg_label_t;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MD_BUSY  = 1'b1;
    localparam reg_label_t X0_LABEL = 5'd0;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    function automatic logic load_use(
        input reg_label_t rs1,
        input reg_label_t rs2,
        input logic       rs1_used,
        input logic       rs2_used,
        input reg_label_t rd,
        input logic       is_load
    );
        return is_load && rd != X0_LABEL && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
    endfunction

endpackage

// File: rtl/ex_hazard_controller_if.sv
// ex_hazard_controller_if: pipeline hazard inputs, mul/div handshake and pipeline-register controls.
interface ex_hazard_controller_if;
    import ex_hazard_controller_pkg::*;

    reg_label_t rs1_label_id_i;
    reg_label_t rs2_label_id_i;
    reg_label_t rd_label_ex_i;
    logic       rs1_used_id_i;
    logic       rs2_used_id_i;
    logic       is_load_instr_ex_i;
    logic       branching_ex_i;
    logic       md_req_ex_i;
    logic       md_done_i;
    logic       md_start_o;
    logic       pc_en_o;
    logic       if_id_en_o;
    logic       id_ex_en_o;
    logic       if_id_flush_o;
    logic       id_ex_flush_o;
    logic       ex_mem_bubble_o;

    modport master (
        input  rs1_label_id_i, rs2_label_id_i, rd_label_ex_i, rs1_used_id_i, rs2_used_id_i,
               is_load_instr_ex_i, branching_ex_i, md_req_ex_i, md_done_i,
        output md_start_o, pc_en_o, if_id_en_o, id_ex_en_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_bubble_o
    );

    modport slave (
        output rs1_label_id_i, rs2_label_id_i, rd_label_ex_i, rs1_used_id_i, rs2_used_id_i,
               is_load_instr_ex_i, branching_ex_i, md_req_ex_i, md_done_i,
        input  md_start_o, pc_en_o, if_id_en_o, id_ex_en_o, if_id_flush_o, id_ex_flush_o,
               ex_mem_bubble_o
    );

endinterface

// File: rtl/ex_hazard_controller_sat_counter.sv
// sat_counter: enabled up-counter that sticks at all-ones, asynchronously cleared.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q <= '0;
        else if (en && !(&q)) q <= q + 1'b1;
    end

endmodule

// File: rtl/ex_hazard_controller.sv
// ex_hazard_controller: EX-stage sequencing of load-use stalls, branch flushes and mul/div occupancy.
module ex_hazard_controller
    import ex_hazard_controller_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    ex_hazard_controller_if.master hz,
    output logic                   md_error_o,
    output logic [CNT_W-1:0]       stall_cnt_o,
    output logic [CNT_W-1:0]       flush_cnt_o
);

    localparam int TW = $clog2(MD_TIMEOUT);

    logic [0:0]    state_q;
    logic [TW-1:0] tmo_q;
    logic          busy, rel, hold, start, lu, br;

    always_comb begin
        busy  = state_q == MD_BUSY;
        rel   = busy && (hz.md_done_i || tmo_q == TW'(MD_TIMEOUT - 1));
        hold  = busy && !rel;
        br    = !busy && hz.branching_ex_i;
        start = !busy && !hz.branching_ex_i && hz.md_req_ex_i;
        lu    = !busy && !hz.branching_ex_i && !hz.md_req_ex_i &&
                load_use(hz.rs1_label_id_i, hz.rs2_label_id_i, hz.rs1_used_id_i,
                         hz.rs2_used_id_i, hz.rd_label_ex_i, hz.is_load_instr_ex_i);
    end

    // Reset forces the pipeline to free-run so nothing is started or flushed while held.
    assign hz.md_start_o      = rst_ni && start;
    assign hz.pc_en_o         = !rst_ni || !(hold || start || lu);
    assign hz.if_id_en_o      = !rst_ni || !(hold || start || lu);
    assign hz.id_ex_en_o      = !rst_ni || !(hold || start);
    assign hz.if_id_flush_o   = rst_ni && br;
    assign hz.id_ex_flush_o   = rst_ni && (br || lu);
    assign hz.ex_mem_bubble_o = rst_ni && (hold || start);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            tmo_q      <= '0;
            md_error_o <= 1'b0;
        end else if (start) begin
            state_q <= MD_BUSY;
            tmo_q   <= '0;
        end else if (rel) begin
            state_q    <= IDLE;
            md_error_o <= md_error_o || !hz.md_done_i;
        end else if (hold) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (!hz.pc_en_o),
        .q      (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en     (br),
        .q      (flush_cnt_o)
    );

endmodule

// File: tb/tb_ex_hazard_controller.sv
// tb_ex_hazard_controller: directed and randomized checks against a cycle-level behavioural model.
module tb_ex_hazard_controller;

    localparam int MD_TIMEOUT = 8;
    localparam int CNT_W      = 4;
    localparam int CMAX       = 15;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             md_error_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    ex_hazard_controller_if hz();

    ex_hazard_controller #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .hz          (hz),
        .md_error_o  (md_error_o),
        .stall_cnt_o (stall_cnt_o),
        .flush_cnt_o (flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: busy flag plus the index of the current mul/div wait cycle (1 = first cycle after start).
    bit m_busy;
    bit m_err;
    int m_cyc;
    int m_stall;
    int m_flush;

    // {md_start, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble}
    function automatic logic [6:0] exp_ctrl();
        logic dep;
        if (!rst_ni) return 7'b0111000;
        if (m_busy) return (hz.md_done_i || m_cyc == MD_TIMEOUT) ? 7'b0111000 : 7'b0000001;
        if (hz.branching_ex_i) return 7'b0111110;
        if (hz.md_req_ex_i) return 7'b1000001;
        dep = hz.is_load_instr_ex_i && hz.rd_label_ex_i != 5'd0 &&
              ((hz.rs1_used_id_i && hz.rs1_label_id_i == hz.rd_label_ex_i) ||
               (hz.rs2_used_id_i && hz.rs2_label_id_i == hz.rd_label_ex_i));
        return dep ? 7'b0001010 : 7'b0111000;
    endfunction

    function automatic logic [6:0] act_ctrl();
        return {hz.md_start_o, hz.pc_en_o, hz.if_id_en_o, hz.id_ex_en_o,
                hz.if_id_flush_o, hz.id_ex_flush_o, hz.ex_mem_bubble_o};
    endfunction

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic [4:0] rd, input logic ld, input logic br, input logic req,
                         input logic done);
        hz.rs1_label_id_i     = rs1;
        hz.rs2_label_id_i     = rs2;
        hz.rs1_used_id_i      = u1;
        hz.rs2_used_id_i      = u2;
        hz.rd_label_ex_i      = rd;
        hz.is_load_instr_ex_i = ld;
        hz.branching_ex_i     = br;
        hz.md_req_ex_i        = req;
        hz.md_done_i          = done;
    endtask

    task automatic model_clear();
        m_busy = 0; m_err = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance one clock edge and the model with it; no checking here.
    task automatic step();
        logic [6:0] e;
        logic br, req, done;
        e = exp_ctrl(); br = hz.branching_ex_i; req = hz.md_req_ex_i; done = hz.md_done_i;
        @(posedge clk_i);
        if (rst_ni) begin
            if (!e[5] && m_stall < CMAX) m_stall++;
            if (!m_busy && br && m_flush < CMAX) m_flush++;
            if (m_busy) begin
                if (done || m_cyc == MD_TIMEOUT) begin
                    m_busy = 0;
                    if (!done) m_err = 1;
                end else m_cyc++;
            end else if (!br && req) begin
                m_busy = 1;
                m_cyc = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        drive(5'd1, 5'd2, 1, 1, 5'd1, 1, 0, 1, 0);
        #12;
        checks++;
        if (act_ctrl() !== exp_ctrl()) begin
            errors++; $display("FAIL reset_ctrl: got %b want %b", act_ctrl(), exp_ctrl());
        end
        checks++;
        if ({md_error_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            errors++; $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d want 0 0 0",
                               md_error_o, stall_cnt_o, flush_cnt_o);
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_load_use();
        logic [4:0] rs1 [6] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9, 5'd4};
        logic [4:0] rs2 [6] = '{5'd1, 5'd1, 5'd0, 5'd7, 5'd9, 5'd8};
        logic       u1  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       u2  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] rd  [6] = '{5'd5, 5'd5, 5'd0, 5'd7, 5'd9, 5'd8};
        logic       ld  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(rs1[i], rs2[i], u1[i], u2[i], rd[i], ld[i], 0, 0, 0);
            @(negedge clk_i);
            checks++;
            if (act_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL load_use[%0d]: got %b want %b", i, act_ctrl(), exp_ctrl());
            end
            step();
            checks++;
            if (stall_cnt_o !== CNT_W'(m_stall)) begin
                errors++; $display("FAIL load_use_stall[%0d]: got %0d want %0d", i, stall_cnt_o, m_stall);
            end
        end
    endtask

    task automatic test_branch_over_hazard();
        drive(5'd5, 5'd1, 1, 1, 5'd5, 1, 1, 1, 0);
        @(negedge clk_i);
        checks++;
        if (act_ctrl() !== exp_ctrl()) begin
            errors++; $display("FAIL branch_ctrl: got %b want %b", act_ctrl(), exp_ctrl());
        end
        step();
        checks++;
        if (flush_cnt_o !== CNT_W'(m_flush) || stall_cnt_o !== CNT_W'(m_stall)) begin
            errors++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want %0d %0d",
                               flush_cnt_o, stall_cnt_o, m_flush, m_stall);
        end
    endtask

    task automatic test_md(input int done_at, input string name);
        int starts = 0;
        for (int c = 0; c <= MD_TIMEOUT; c++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, c == done_at);
            @(negedge clk_i);
            checks++;
            if (act_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL %s_ctrl[%0d]: got %b want %b", name, c, act_ctrl(), exp_ctrl());
            end
            starts += int'(hz.md_start_o);
            step();
            if (c == done_at) break;
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        checks++;
        if (starts !== 1) begin
            errors++; $display("FAIL %s_starts: got %0d want 1", name, starts);
        end
        checks++;
        if (stall_cnt_o !== CNT_W'(m_stall) || md_error_o !== m_err) begin
            errors++; $display("FAIL %s_regs: got stall=%0d err=%b want %0d %b",
                               name, stall_cnt_o, md_error_o, m_stall, m_err);
        end
        repeat (3) step();
        checks++;
        if (md_error_o !== m_err) begin
            errors++; $display("FAIL %s_sticky: got %b want %b", name, md_error_o, m_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 10; c++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, m_busy && m_cyc == 2);
            @(negedge clk_i);
            checks++;
            if (act_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL b2b_ctrl[%0d]: got %b want %b", c, act_ctrl(), exp_ctrl());
            end
            step();
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        while (m_busy) step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            @(negedge clk_i);
            checks++;
            if (act_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL rand_ctrl[%0d]: got %b want %b", c, act_ctrl(), exp_ctrl());
            end
            step();
            checks++;
            if (stall_cnt_o !== CNT_W'(m_stall) || flush_cnt_o !== CNT_W'(m_flush) ||
                md_error_o !== m_err) begin
                errors++; $display("FAIL rand_regs[%0d]: got %0d/%0d/%b want %0d/%0d/%b", c,
                                   stall_cnt_o, flush_cnt_o, md_error_o, m_stall, m_flush, m_err);
            end
        end
    endtask

    task automatic test_saturation();
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1);
        while (m_busy) step();
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0);
        repeat (CMAX + 4) step();
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        repeat (CMAX + 4) step();
        checks++;
        if (flush_cnt_o !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_flush: got %0d want %0d", flush_cnt_o, CMAX);
        end
        checks++;
        if (stall_cnt_o !== CNT_W'(CMAX)) begin
            errors++; $display("FAIL sat_stall: got %0d want %0d", stall_cnt_o, CMAX);
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0);
        while (m_busy) step();
    endtask

    task automatic test_reset_mid_busy();
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0);
        step();
        step();
        #2;
        rst_ni = 1'b0;
        model_clear();
        #1;
        checks++;
        if (act_ctrl() !== exp_ctrl()) begin
            errors++; $display("FAIL rst_busy_ctrl: got %b want %b", act_ctrl(), exp_ctrl());
        end
        checks++;
        if ({md_error_o, stall_cnt_o, flush_cnt_o} !== '0) begin
            errors++; $display("FAIL rst_busy_regs: got err=%b stall=%0d flush=%0d want 0 0 0",
                               md_error_o, stall_cnt_o, flush_cnt_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (act_ctrl() !== exp_ctrl()) begin
                errors++; $display("FAIL rst_busy_after[%0d]: got %b want %b", c, act_ctrl(), exp_ctrl());
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_over_hazard();
        test_md(5, "md_done");
        test_md(MD_TIMEOUT + 10, "md_timeout");
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
